// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI write controller.
//   - Frame layout: 16 bits, {rw, addr[6:0], data[7:0]}, rw bit first on the wire.
//   - Register map of the paired SPI register peripheral.
//   - FSM state encoding used by spi_controller.
package spi_pkg;

  localparam int SPI_FRAME_W   = 16;
  localparam int SPI_RW_BIT    = 15;
  localparam int SPI_ADDR_MSB  = 14;
  localparam int SPI_ADDR_LSB  = 8;
  localparam int SPI_DATA_MSB  = 7;
  localparam int SPI_DATA_LSB  = 0;

  localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] REG_PWM_DUTY    = 7'h04;
  localparam logic [6:0] SPI_MAX_ADDR    = REG_PWM_DUTY;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  // Write frame: the rw bit is always 1, this controller never reads.
  function automatic logic [SPI_FRAME_W-1:0] spi_write_frame(input logic [6:0] addr,
                                                             input logic [7:0] data);
    logic [SPI_FRAME_W-1:0] f;
    f = '0;
    f[SPI_RW_BIT] = 1'b1;
    f[SPI_ADDR_MSB:SPI_ADDR_LSB] = addr;
    f[SPI_DATA_MSB:SPI_DATA_LSB] = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter for the SPI clock.
//   clk_i   in  system clock
//   rst_i   in  synchronous active-high reset
//   en_i    in  count enable (frame in progress)
//   clr_i   in  restart the half-period from zero
//   tick_o  out high on the last cycle of each CLK_DIV-cycle half-period
// The counter wraps to zero on its own, so back-to-back half-periods need
// no extra handling from the FSM.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 write-only master for the SPI register peripheral.
//   clk_i        in   system clock
//   rst_i        in   synchronous active-high reset
//   req_valid_i  in   request present
//   req_ready_o  out  request accepted when high together with req_valid_i
//   req_addr_i   in   7-bit register address
//   req_data_i   in   8-bit register data
//   busy_o       out  frame or idle gap in progress
//   done_o       out  one-cycle pulse on the first cycle after a frame
//   err_o        out  one-cycle pulse after an out-of-range request
//   sclk_o       out  SPI clock, idles low
//   ncs_o        out  active-low chip select
//   copi_o       out  serial data, MSB first
// Optional build macro SPI_CTRL_ADDR_CHECK_EN: requests above MAX_ADDR are
// accepted but not transmitted, and err_o pulses instead. Without it err_o is 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a request, req_ready_o high
// ST_SETUP | ncs low, first bit on copi, one half-period before first rise
// ST_SHIFT | 16 bits, each one high half-period then one low half-period
// ST_HOLD  | ncs still low for one half-period after the last fall
// ST_GAP   | ncs high for IDLE_GAP cycles before the next accept
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 4
`ifdef SPI_CTRL_ADDR_CHECK_EN
  ,
  parameter logic [6:0] MAX_ADDR = SPI_MAX_ADDR
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [6:0] req_addr_i,
  input  logic [7:0] req_data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       sclk_o,
  output logic       ncs_o,
  output logic       copi_o
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [4:0] LAST_BIT = 5'd15;

  spi_state_t             state_q, state_d;
  logic [SPI_FRAME_W-1:0] shift_q, shift_d;
  logic [4:0]             bit_q, bit_d;
  logic                   high_q, high_d;   // current SHIFT half-period has sclk high
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   done_q, done_d;
  logic                   accept;
  logic                   frame_active;
  logic                   tick;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (frame_active),
    .clr_i  (accept),
    .tick_o (tick)
  );

  assign frame_active = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                        (state_q == ST_HOLD);
  assign req_ready_o  = (state_q == ST_IDLE);
  assign accept       = req_valid_i && req_ready_o;
  assign busy_o       = (state_q != ST_IDLE);
  assign ncs_o        = !frame_active;
  assign sclk_o       = (state_q == ST_SHIFT) && high_q;
  // The shift register is empty by HOLD, so copi returns to 0 there as well.
  assign copi_o       = frame_active && shift_q[SPI_FRAME_W-1];
  assign done_o       = done_q;

`ifdef SPI_CTRL_ADDR_CHECK_EN
  logic err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    high_d  = high_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef SPI_CTRL_ADDR_CHECK_EN
          if (req_addr_i > MAX_ADDR) begin
            err_d = 1'b1;
          end else begin
            shift_d = spi_write_frame(req_addr_i, req_data_i);
            state_d = ST_SETUP;
          end
`else
          shift_d = spi_write_frame(req_addr_i, req_data_i);
          state_d = ST_SETUP;
`endif
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          high_d  = 1'b1;
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (high_q) begin
            // Falling edge: present the next bit in the same cycle.
            high_d  = 1'b0;
            shift_d = {shift_q[SPI_FRAME_W-2:0], 1'b0};
          end else if (bit_q == LAST_BIT) begin
            state_d = ST_HOLD;
          end else begin
            bit_d  = bit_q + 5'd1;
            high_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
          gap_d   = GAP_W'(IDLE_GAP - 1);
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      high_q  <= 1'b0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      high_q  <= high_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_CTRL_ADDR_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed bench for spi_controller with a small model of
// the paired SPI register peripheral (5 registers, writes only on complete
// 16-bit frames with the rw bit set and an address in range).
module tb_spi_controller;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy, done, err, sclk, ncs, copi;

  always #5 clk = ~clk;

  spi_controller dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .sclk_o      (sclk),
    .ncs_o       (ncs),
    .copi_o      (copi)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Peripheral model
  logic [15:0] rx_sh      = '0;
  int          rx_cnt     = 0;
  logic [15:0] last_frame = '0;
  int          last_cnt   = 0;
  int          sclk_rises = 0;
  logic [7:0]  pregs [0:4];

  initial for (int i = 0; i < 5; i++) pregs[i] = 8'h00;

  always @(negedge ncs) begin
    rx_cnt = 0;
    rx_sh  = '0;
  end

  always @(posedge sclk) begin
    sclk_rises++;
    if (ncs === 1'b0) begin
      rx_sh = {rx_sh[14:0], copi};
      rx_cnt++;
    end
  end

  always @(posedge ncs) begin
    int idx;
    last_frame = rx_sh;
    last_cnt   = rx_cnt;
    idx        = int'(rx_sh[14:8]);
    if (rx_cnt == 16 && rx_sh[15] && idx <= 4) pregs[idx] = rx_sh[7:0];
  end

  // Cycle-level monitor; samples pre-edge values at each rising clock edge.
  int   cyc = 0, acc_cnt = 0, acc_cyc = 0, rise_cyc = 0, ncs_low_cyc = 0;
  int   done_cnt = 0, err_cnt = 0, ready_viol = 0, ncs_falls = 0;
  logic ncs_prev = 1'b1;

  always @(posedge clk) begin
    if (req_valid && req_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (ncs === 1'b1 && ncs_prev === 1'b0) rise_cyc = cyc;
    if (ncs === 1'b0) begin
      if (ncs_prev === 1'b1) begin
        ncs_low_cyc = 1;
        ncs_falls++;
      end else begin
        ncs_low_cyc++;
      end
      if (req_ready) ready_viol++;
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    ncs_prev = ncs;
    cyc++;
  end

  task automatic send(input logic [6:0] a, input logic [7:0] d, input bit keep);
    int n;
    int acc0;
    n = 0;
    @(negedge clk);
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    acc0      = acc_cnt;
    while (acc_cnt == acc0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept", acc_cnt - acc0, 1);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, f0, a0, n, base;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ncs",   ncs, 1);
    check("rst_sclk",  sclk, 0);
    check("rst_copi",  copi, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_err",   err, 0);
    check("rst_ready", req_ready, 1);

    // 1: addr 0, data A5 -> 1,0000000,10100101
    d0 = done_cnt;
    send(REG_EN_OUT_7_0, 8'hA5, 1'b0);
    wait_idle();
    check("t1_frame", last_frame, 16'h80A5);
    check("t1_bits",  last_cnt, 16);
    check("t1_reg0",  pregs[0], 8'hA5);
    check("t1_done",  done_cnt - d0, 1);

    // 2: addr 4, data 80; ncs low for 34*4 cycles
    send(REG_PWM_DUTY, 8'h80, 1'b0);
    wait_idle();
    check("t2_ncs_low", ncs_low_cyc, 136);
    check("t2_rises",   last_cnt, 16);
    check("t2_frame",   last_frame, 16'h8480);
    check("t2_reg4",    pregs[4], 8'h80);

    // 3: back-to-back with req_valid held high
    send(REG_EN_PWM_7_0, 8'h5A, 1'b1);
    req_addr = REG_EN_PWM_15_8;
    req_data = 8'hC3;
    a0 = acc_cnt;
    n  = 0;
    while (acc_cnt == a0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    check("t3_second_accept", acc_cnt - a0, 1);
    check("t3_gap", acc_cyc - rise_cyc, 4);
    check("t3_frame1", last_frame, 16'h825A);
    check("t3_reg2", pregs[2], 8'h5A);
    wait_idle();
    check("t3_frame2", last_frame, 16'h83C3);
    check("t3_reg3", pregs[3], 8'hC3);
    check("t3_ready_low", ready_viol, 0);

    // 6: inputs change mid-frame, latched values are sent
    send(REG_EN_OUT_15_8, 8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    req_addr = REG_EN_PWM_7_0;
    req_data = 8'hFF;
    wait_idle();
    check("t6_frame", last_frame, 16'h813C);
    check("t6_reg1", pregs[1], 8'h3C);
    check("t6_reg2", pregs[2], 8'h5A);

    // 4: reset after the 5th sclk rise
    d0   = done_cnt;
    base = sclk_rises;
    send(REG_EN_OUT_7_0, 8'h77, 1'b0);
    n = 0;
    while (sclk_rises < base + 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t4_rises", sclk_rises - base, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t4_ncs",  ncs, 1);
    check("t4_sclk", sclk, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_done", done_cnt - d0, 0);
    check("t4_bits", last_cnt, 5);
    check("t4_reg0", pregs[0], 8'hA5);
    check("t4_ready", req_ready, 1);

    // 5: out-of-range address
    d0 = done_cnt;
    e0 = err_cnt;
    f0 = ncs_falls;
`ifdef SPI_CTRL_ADDR_CHECK_EN
    send(7'h05, 8'h11, 1'b0);
    repeat (20) @(negedge clk);
    check("t5_err",   err_cnt - e0, 1);
    check("t5_falls", ncs_falls - f0, 0);
    check("t5_done",  done_cnt - d0, 0);
`else
    send(7'h05, 8'h11, 1'b0);
    wait_idle();
    check("t5_err",   err_cnt - e0, 0);
    check("t5_falls", ncs_falls - f0, 1);
    check("t5_frame", last_frame, 16'h8511);
    check("t5_done",  done_cnt - d0, 1);
`endif
    check("t5_reg0", pregs[0], 8'hA5);
    check("t5_reg1", pregs[1], 8'h3C);
    check("t5_reg2", pregs[2], 8'h5A);
    check("t5_reg3", pregs[3], 8'hC3);
    check("t5_reg4", pregs[4], 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
